// File: rtl/vec_cfg_pkg.sv
// Shared definitions for the vector-table register bank: reset values, register
// offsets, FSM state encoding and the offset-to-index decode.
package vec_cfg_pkg;

  localparam logic [31:0] SP_RST    = 32'h0000_4000;
  localparam logic [31:0] RESET_RST = 32'h0000_0100;
  localparam logic [31:0] VEC_RST   = 32'h0000_0000;

  localparam logic [15:0] SP_OFF    = 16'h0000;
  localparam logic [15:0] RESET_OFF = 16'h0004;
  localparam logic [15:0] NMI_OFF   = 16'h0008;
  localparam logic [15:0] FAULT_OFF = 16'h000C;
  localparam logic [15:0] IRQ0_OFF  = 16'h0040;
  localparam logic [15:0] IRQ15_OFF = 16'h007C;
  localparam logic [15:0] LOCK_OFF  = 16'h0080;

  localparam int         NUM_VEC  = 20;
  localparam logic [4:0] LOCK_IDX = 5'd20;

  localparam int ST_IDLE  = 0;
  localparam int ST_WDATA = 1;
  localparam int ST_ERR1  = 2;
  localparam int ST_ERR2  = 3;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    WDATA = 4'b0010,
    ERR1  = 4'b0100,
    ERR2  = 4'b1000
  } state_t;

  // Returns {valid, index}; index 0..19 are vectors, LOCK_IDX is the lock register.
  function automatic logic [5:0] off2idx(input logic [15:0] off);
    logic [5:0] r;
    r = '0;
    if (off == SP_OFF)         r = {1'b1, 5'd0};
    else if (off == RESET_OFF) r = {1'b1, 5'd1};
    else if (off == NMI_OFF)   r = {1'b1, 5'd2};
    else if (off == FAULT_OFF) r = {1'b1, 5'd3};
    else if (off >= IRQ0_OFF && off <= IRQ15_OFF && off[1:0] == 2'b00)
      r = {1'b1, 5'd4 + {1'b0, off[5:2]}};
    else if (off == LOCK_OFF)  r = {1'b1, LOCK_IDX};
    return r;
  endfunction

  function automatic logic [31:0] vec_rst(input int i);
    if (i == 0)      return SP_RST;
    else if (i == 1) return RESET_RST;
    else             return VEC_RST;
  endfunction

endpackage

// File: rtl/vec_cfg_dec.sv
// Address-phase checker: flags a transfer as legal and yields its register index.
module vec_cfg_dec
  import vec_cfg_pkg::*;
(
  input  logic [15:0] addr,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic        lock_eff,
  output logic        legal,
  output logic [4:0]  idx
);

  logic [5:0] dec;

  always_comb begin
    dec   = off2idx(addr);
    idx   = dec[4:0];
    legal = (addr[15:8] == 8'h00) && (addr[1:0] == 2'b00) && (hsize == 3'b010)
            && dec[5] && !(hwrite && lock_eff);
  end

endmodule

// File: rtl/vec_cfg.sv
// AHB-lite register bank holding the programmable vector table with a sticky
// write lock. Reads are zero-wait; errors use the two-cycle AHB response.
module vec_cfg
  import vec_cfg_pkg::*;
(
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic [31:0] sp_addr,
  output logic [31:0] reset_addr,
  output logic [31:0] nmi_addr,
  output logic [31:0] fault_addr,
  output logic [31:0] irq0_addr,
  output logic [31:0] irq1_addr,
  output logic [31:0] irq2_addr,
  output logic [31:0] irq3_addr,
  output logic [31:0] irq4_addr,
  output logic [31:0] irq5_addr,
  output logic [31:0] irq6_addr,
  output logic [31:0] irq7_addr,
  output logic [31:0] irq8_addr,
  output logic [31:0] irq9_addr,
  output logic [31:0] irq10_addr,
  output logic [31:0] irq11_addr,
  output logic [31:0] irq12_addr,
  output logic [31:0] irq13_addr,
  output logic [31:0] irq14_addr,
  output logic [31:0] irq15_addr,
  output logic        locked,
  output logic [3:0]  fsm_state
);

  // Handshake: a transfer is taken when hsel & hready & htrans[1] at a rising
  // hclk; write data follows in the next cycle, read data is returned then too.
  logic [31:0] vecs [NUM_VEC];
  state_t      state;
  logic [4:0]  wr_idx;
  logic        accept, legal, lock_pend, lock_eff;
  logic [4:0]  idx;
  logic [31:0] rd_val;
  logic        unused_bits;

  assign hready    = ~state[ST_ERR1];
  assign hresp     = state[ST_ERR1] | state[ST_ERR2];
  assign fsm_state = state;
  assign accept    = hsel & hready & htrans[1];
  assign unused_bits = ^{haddr[31:16], htrans[0]};

  // A lock write still in its data phase already blocks the next write.
  assign lock_pend = state[ST_WDATA] & (wr_idx == LOCK_IDX) & hwdata[0];
  assign lock_eff  = locked | lock_pend;

  vec_cfg_dec u_dec (
    .addr     (haddr[15:0]),
    .hsize    (hsize),
    .hwrite   (hwrite),
    .lock_eff (lock_eff),
    .legal    (legal),
    .idx      (idx)
  );

  always_comb begin
    rd_val = '0;
    if (idx == LOCK_IDX)                         rd_val = {31'b0, lock_eff};
    else if (state[ST_WDATA] && (wr_idx == idx)) rd_val = hwdata;
    else                                         rd_val = vecs[idx];
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state  <= IDLE;
      wr_idx <= '0;
      locked <= 1'b0;
      hrdata <= '0;
      for (int i = 0; i < NUM_VEC; i++) vecs[i] <= vec_rst(i);
    end else begin
      if (state[ST_WDATA]) begin
        if (wr_idx == LOCK_IDX) locked <= locked | hwdata[0];
        else                    vecs[wr_idx] <= hwdata;
      end
      hrdata <= '0;
      if (accept) begin
        if (!legal) begin
          state <= ERR1;
        end else if (hwrite) begin
          state  <= WDATA;
          wr_idx <= idx;
        end else begin
          state  <= IDLE;
          hrdata <= rd_val;
        end
      end else if (state[ST_ERR1]) begin
        state <= ERR2;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign sp_addr    = vecs[0];
  assign reset_addr = vecs[1];
  assign nmi_addr   = vecs[2];
  assign fault_addr = vecs[3];
  assign irq0_addr  = vecs[4];
  assign irq1_addr  = vecs[5];
  assign irq2_addr  = vecs[6];
  assign irq3_addr  = vecs[7];
  assign irq4_addr  = vecs[8];
  assign irq5_addr  = vecs[9];
  assign irq6_addr  = vecs[10];
  assign irq7_addr  = vecs[11];
  assign irq8_addr  = vecs[12];
  assign irq9_addr  = vecs[13];
  assign irq10_addr = vecs[14];
  assign irq11_addr = vecs[15];
  assign irq12_addr = vecs[16];
  assign irq13_addr = vecs[17];
  assign irq14_addr = vecs[18];
  assign irq15_addr = vecs[19];

endmodule
